// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared widths, ALU codes and ID/EX held-state struct
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 5;

    localparam logic [CTRL_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [CTRL_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [CTRL_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [CTRL_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [CTRL_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [CTRL_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [CTRL_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [CTRL_W-1:0] ALU_OR     = 5'd8;
    localparam logic [CTRL_W-1:0] ALU_AND    = 5'd9;
    localparam logic [CTRL_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [CTRL_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [CTRL_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [CTRL_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [CTRL_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [CTRL_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [CTRL_W-1:0] ALU_REM    = 5'd16;
    localparam logic [CTRL_W-1:0] ALU_REMU   = 5'd17;
    localparam logic [CTRL_W-1:0] ALU_EQ     = 5'd18;
    localparam logic [CTRL_W-1:0] ALU_NE     = 5'd19;
    localparam logic [CTRL_W-1:0] ALU_AUIPC  = 5'd20;
    localparam logic [CTRL_W-1:0] ALU_LUI    = 5'd21;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] alu_control;
        logic              alu_src_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    // Substitute the value being written back this cycle; x0 is never replaced.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_result
    );
        if (wb_we && (wb_rd == rs) && (rs != '0)) begin
            return wb_result;
        end
        return data;
    endfunction

endpackage

// File: rtl/operand_fwd.sv
// rtl/operand_fwd.sv - per-operand EX/MEM and MEM/WB forwarding mux
module operand_fwd
    import rv_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   stored_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   fwd_data
);

    // A load in EX/MEM has no data yet; the hazard logic stalls instead.
    always_comb begin
        fwd_data = stored_data;
        if (exm_reg_write && !exm_mem_read && (exm_rd == rs) && (rs != '0)) begin
            fwd_data = exm_result;
        end else if (wb_reg_write && (wb_rd == rs) && (rs != '0)) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use stall
module id_ex_stage
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic              id_alu_src_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   src_a,
    output logic [XLEN-1:0]   src_b,
    output logic [4:0]        shamt,
    output logic [CTRL_W-1:0] alu_control,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc
);

    logic   held_valid_q, held_valid_d;
    id_ex_t held_q, held_d;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            rs2_used, hazard, transfer, capture;

    operand_fwd u_fwd_rs1 (
        .rs            (held_q.rs1),
        .stored_data   (held_q.rs1_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs1)
    );

    operand_fwd u_fwd_rs2 (
        .rs            (held_q.rs2),
        .stored_data   (held_q.rs2_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs2)
    );

    // Stores read rs2 even when SrcB takes the immediate.
    assign rs2_used = !held_q.alu_src_imm || held_q.mem_write;
    assign hazard   = held_valid_q && exm_reg_write && exm_mem_read && (exm_rd != '0) &&
                      ((exm_rd == held_q.rs1) || (rs2_used && (exm_rd == held_q.rs2)));

    assign ex_valid = held_valid_q && !hazard;
    assign transfer = ex_valid && ex_ready;
    assign id_ready = !held_valid_q || transfer;
    assign capture  = id_valid && id_ready && !flush;

    always_comb begin
        held_valid_d = held_valid_q;
        held_d       = held_q;
        if (flush) begin
            held_valid_d = 1'b0;
        end else if (capture) begin
            held_valid_d       = 1'b1;
            held_d.pc          = id_pc;
            held_d.rs1         = id_rs1;
            held_d.rs2         = id_rs2;
            held_d.rd          = id_rd;
            held_d.rs1_data    = wb_bypass(id_rs1, id_rs1_data, wb_reg_write, wb_rd, wb_result);
            held_d.rs2_data    = wb_bypass(id_rs2, id_rs2_data, wb_reg_write, wb_rd, wb_result);
            held_d.imm         = id_imm;
            held_d.alu_control = id_alu_control;
            held_d.alu_src_imm = id_alu_src_imm;
            held_d.reg_write   = id_reg_write;
            held_d.mem_read    = id_mem_read;
            held_d.mem_write   = id_mem_write;
        end else if (transfer) begin
            held_valid_d = 1'b0;
        end else if (held_valid_q) begin
            // A stalled instruction would otherwise lose a writeback that retires under it.
            held_d.rs1_data = wb_bypass(held_q.rs1, held_q.rs1_data, wb_reg_write, wb_rd, wb_result);
            held_d.rs2_data = wb_bypass(held_q.rs2, held_q.rs2_data, wb_reg_write, wb_rd, wb_result);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            held_q       <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_q       <= held_d;
        end
    end

    assign src_a         = fwd_rs1;
    assign src_b         = held_q.alu_src_imm ? held_q.imm : fwd_rs2;
    assign shamt         = held_q.imm[4:0];
    assign alu_control   = held_q.alu_control;
    assign ex_rd         = held_q.rd;
    assign ex_reg_write  = held_q.reg_write;
    assign ex_mem_read   = held_q.mem_read;
    assign ex_mem_write  = held_q.mem_write;
    assign ex_store_data = fwd_rs2;
    assign ex_pc         = held_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import rv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic [CTRL_W-1:0] id_alu_control;
    logic              id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [REG_AW-1:0] exm_rd;
    logic              exm_reg_write, exm_mem_read;
    logic [XLEN-1:0]   exm_result;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [XLEN-1:0]   wb_result;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   src_a, src_b;
    logic [4:0]        shamt;
    logic [CTRL_W-1:0] alu_control;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic [XLEN-1:0]   ex_store_data, ex_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_result(wb_result), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .src_a(src_a), .src_b(src_b), .shamt(shamt), .alu_control(alu_control),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [4:0] op, input logic src_imm);
        id_valid       = 1'b1;
        id_pc          = pc;
        id_rs1         = rs1;
        id_rs1_data    = d1;
        id_rs2         = rs2;
        id_rs2_data    = d2;
        id_rd          = rd;
        id_imm         = imm;
        id_alu_control = op;
        id_alu_src_imm = src_imm;
        id_reg_write   = 1'b1;
        id_mem_read    = 1'b0;
        id_mem_write   = 1'b0;
    endtask

    task automatic clear_fwd();
        exm_rd = '0; exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_result = '0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        offer(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD, 1'b0);
        id_valid = 1'b0; id_reg_write = 1'b0;
        clear_fwd();
        tick(); tick();
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_alu_control", {27'b0, alu_control}, 32'd0);
        chk("rst_src_a", src_a, 32'd0);
        chk("rst_src_b", src_b, 32'd0);
        chk("rst_ex_reg_write", {31'b0, ex_reg_write}, 32'd0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD x3,x1,x2 with x1=5, x2=7
        offer(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, ALU_ADD, 1'b0);
        #1 chk("add_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        id_valid = 1'b0;
        #1;
        chk("add_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_src_a", src_a, 32'd5);
        chk("add_src_b", src_b, 32'd7);
        chk("add_ex_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_stall_id_ready", {31'b0, id_ready}, 32'd0);

        // back-to-back at one per cycle
        ex_ready = 1'b1;
        offer(32'h10, 5'd4, 32'h11, 5'd5, 32'h22, 5'd6, 32'h0, ALU_SUB, 1'b0);
        #1 chk("b2b_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        offer(32'h14, 5'd7, 32'h33, 5'd8, 32'h44, 5'd9, 32'h0, ALU_XOR, 1'b0);
        #1;
        chk("b2b1_pc", ex_pc, 32'h10);
        chk("b2b1_src_a", src_a, 32'h11);
        chk("b2b1_alu", {27'b0, alu_control}, 32'd1);
        chk("b2b1_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        id_valid = 1'b0;
        #1;
        chk("b2b2_pc", ex_pc, 32'h14);
        chk("b2b2_src_b", src_b, 32'h44);
        chk("b2b2_ex_valid", {31'b0, ex_valid}, 32'd1);
        tick();
        chk("b2b_drain", {31'b0, ex_valid}, 32'd0);

        // EX/MEM over WB priority, then stored data, then WB alone
        ex_ready = 1'b0;
        offer(32'h20, 5'd1, 32'h1, 5'd2, 32'h2, 5'd10, 32'h0, ALU_ADD, 1'b0);
        tick();
        id_valid = 1'b0;
        exm_rd = 5'd1; exm_reg_write = 1'b1; exm_result = 32'h100;
        wb_rd = 5'd1; wb_reg_write = 1'b1; wb_result = 32'h200;
        #1 chk("fwd_exm_prio", src_a, 32'h100);
        exm_reg_write = 1'b0;
        #1 chk("fwd_wb", src_a, 32'h200);
        exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hDEAD; wb_reg_write = 1'b0;
        #1 chk("fwd_stored", src_a, 32'h1);
        clear_fwd();

        // load-use on rs2
        ex_ready = 1'b1;
        exm_rd = 5'd2; exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_result = 32'hBAD;
        #1;
        chk("lu_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_id_ready", {31'b0, id_ready}, 32'd0);
        tick();
        clear_fwd();
        wb_rd = 5'd2; wb_reg_write = 1'b1; wb_result = 32'h44;
        #1;
        chk("lu_src_b", src_b, 32'h44);
        chk("lu_resolved", {31'b0, ex_valid}, 32'd1);
        chk("lu_pc", ex_pc, 32'h20);
        tick();
        clear_fwd();

        // immediate form: rs2 unused, so a load to rs2 does not stall
        ex_ready = 1'b0;
        offer(32'h30, 5'd6, 32'h60, 5'd2, 32'h99, 5'd11, 32'h25, ALU_SLL, 1'b1);
        tick();
        id_valid = 1'b0;
        exm_rd = 5'd2; exm_reg_write = 1'b1; exm_mem_read = 1'b1;
        #1;
        chk("imm_src_b", src_b, 32'h25);
        chk("imm_shamt", {27'b0, shamt}, 32'd5);
        chk("imm_store_data", ex_store_data, 32'h99);
        chk("imm_rs2_unused", {31'b0, ex_valid}, 32'd1);
        exm_rd = 5'd6;
        #1 chk("imm_rs1_hazard", {31'b0, ex_valid}, 32'd0);
        clear_fwd();

        // stall refresh
        ex_ready = 1'b1;
        offer(32'h34, 5'd1, 32'h3, 5'd0, 32'h0, 5'd12, 32'h0, ALU_OR, 1'b0);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        tick();
        wb_rd = 5'd1; wb_reg_write = 1'b1; wb_result = 32'h9;
        tick();
        clear_fwd();
        tick();
        ex_ready = 1'b1;
        #1;
        chk("refresh_src_a", src_a, 32'h9);
        chk("refresh_ex_valid", {31'b0, ex_valid}, 32'd1);
        tick();
        chk("refresh_out", {31'b0, ex_valid}, 32'd0);

        // flush with a held instruction and a capturable offer
        ex_ready = 1'b0;
        offer(32'h40, 5'd3, 32'h3, 5'd4, 32'h4, 5'd13, 32'h0, ALU_AND, 1'b0);
        tick();
        ex_ready = 1'b1;
        offer(32'h44, 5'd5, 32'h5, 5'd6, 32'h6, 5'd14, 32'h0, ALU_SUB, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("flush_dropped", {31'b0, ex_valid}, 32'd0);

        // capture bypass from WB, x0 never forwarded
        ex_ready = 1'b0;
        offer(32'h50, 5'd7, 32'h70, 5'd0, 32'h0, 5'd15, 32'h0, ALU_AND, 1'b0);
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_result = 32'h77;
        tick();
        id_valid = 1'b0;
        clear_fwd();
        exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hBAD;
        #1;
        chk("bypass_src_a", src_a, 32'h77);
        chk("x0_src_b", src_b, 32'h0);
        clear_fwd();

        // asynchronous reset while holding
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("async_rst_alu", {27'b0, alu_control}, 32'd0);
        chk("async_rst_src_a", src_a, 32'd0);
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
